// File: rtl/dreg_arb_pkg.sv
// Shared types and helpers for the round-robin D-register arbiter.
// Holds the FSM state encoding and the one-hot grant helper.
package dreg_arb_pkg;

  localparam int ST_W     = 2;
  localparam int MAX_NREQ = 32;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Returns a MAX_NREQ-wide one-hot vector; callers size-cast it down to NREQ.
  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx,
                                                 input int unsigned nreq);
    logic [MAX_NREQ-1:0] one;
    one = {{(MAX_NREQ-1){1'b0}}, 1'b1};
    return (idx < nreq) ? (one << idx) : '0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first active request strictly after
// last_winner, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // NOTE: every variable written here gets a default before the loop, otherwise
  // the paths where no request matches would infer latches.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IDX_W'((int'(last_winner) + off) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/dreg_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit D-register (Q/Q_bar) among NREQ
// requesters. Optional forced release after HOLD_MAX cycles: DREG_TIMEOUT_EN.
module dreg_rr_arbiter
  import dreg_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   din,
  output logic [NREQ-1:0]         gnt,
  output logic                    ack,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [WIDTH-1:0]        Q,
  output logic [WIDTH-1:0]        Q_bar,
  output logic                    timeout
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("dreg_rr_arbiter: NREQ must be in 2..32");
  end
  if (HOLD_MAX < 2) begin : g_bad_hold
    $error("dreg_rr_arbiter: HOLD_MAX must be at least 2");
  end

  state_t           state;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [WIDTH-1:0] din_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_din
    assign din_arr[g] = din[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req         (req),
    .last_winner (last_winner),
    .winner      (winner),
    .any_req     (any_req)
  );

`ifdef DREG_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] hold_cnt;
`else
  assign timeout = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      ack         <= 1'b0;
      owner       <= '0;
      busy        <= 1'b0;
      Q           <= '0;
      last_winner <= IDX_W'(NREQ - 1);
`ifdef DREG_TIMEOUT_EN
      hold_cnt    <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef DREG_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= NREQ'(onehot(32'(winner), NREQ));
            owner <= winner;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end

        GRANT: begin
          if (req[owner]) begin
            Q     <= din_arr[owner];
            ack   <= 1'b1;
            state <= HOLD;
`ifdef DREG_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            // Abort still counts as this requester's turn.
            gnt         <= '0;
            busy        <= 1'b0;
            last_winner <= owner;
            state       <= IDLE;
          end
        end

        HOLD: begin
          if (!req[owner]) begin
            gnt         <= '0;
            busy        <= 1'b0;
            last_winner <= owner;
            state       <= IDLE;
`ifdef DREG_TIMEOUT_EN
          end else if (hold_cnt == CNT_W'(HOLD_MAX - 1)) begin
            gnt         <= '0;
            busy        <= 1'b0;
            timeout     <= 1'b1;
            last_winner <= owner;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end

        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign Q_bar = ~Q;

endmodule
